mem_port_arbiter: RTL

- Shares the single-port synchronous main memory between two requesters.
- Requester 0 is the CPU control unit's memory path (MAR/MDR read/write strobes). Requester 1 is the program loader/debug port.
- Each access runs as a multi-cycle transaction with a req/ack handshake. Requesters stall on ack.
- Grants are round-robin, so neither requester can starve the other.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/rr_pick2.sv | 14 +
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port main-memory arbiter.
// Holds the FSM state type, requester ids and the wait-counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CPU_ID = 1'b0;
  localparam logic LDR_ID = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// A lone request wins outright; on a tie the requester named by ptr wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic id
);

  assign valid = req0 | req1;
  assign id    = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port synchronous main memory between the CPU path
// and the loader/debug port with req/ack handshakes and round-robin grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

  state_t             state, state_nxt;
  logic               ptr;
  logic               gnt_id;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [CNT_W-1:0]   cnt;
  logic               pick_vld;
  logic               pick_id;
  logic               take;
  logic               capture;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .valid (pick_vld),
    .id    (pick_id)
  );

  assign take    = (state == IDLE) && pick_vld;
  assign capture = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes exist only in ISSUE, so idle address/data lines stay at zero
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      ISSUE: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_we    = lat_we;
        mem_re    = ~lat_we;
      end
      DONE: begin
        ack0 = (gnt_id == CPU_ID);
        ack1 = (gnt_id == LDR_ID);
      end
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign grant = gnt_id;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_id <= CPU_ID;
      lat_we <= 1'b0;
      cnt    <= '0;
      ptr    <= CPU_ID;
    end else begin
      if (take) begin
        gnt_id <= pick_id;
        lat_we <= pick_id ? we1 : we0;
      end
      if ((state == ISSUE) && !lat_we)      cnt <= LAT_M1;
      else if ((state == WAIT) && cnt != '0) cnt <= cnt - 1'b1;
      if (state == DONE) ptr <= ~gnt_id;
    end
  end

  // Address and write data are only observed in ISSUE, after a fresh latch
  always_ff @(posedge clock) begin
    if (take) begin
      lat_addr  <= pick_id ? addr1 : addr0;
      lat_wdata <= pick_id ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (capture) begin
      if (gnt_id == CPU_ID) rdata0 <= mem_rdata;
      else                  rdata1 <= mem_rdata;
    end
  end

endmodule
